uart_prog_loader: RTL and testbench

Serial program loader that is the writing end of the processor's instruction-memory interface. The processor core only reads instruction memory. This block receives a framed program image over a UART line, writes it word-by-word into instruction memory, and holds the CPU stalled until the image is complete. It sits beside the processor top level and drives the instruction-memory write port and the CPU hold input.

---
 rtl/uart_prog_loader.sv | 219 +++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART program loader: receives a framed image (0xA5, length, 16-bit words) and writes it
// into instruction memory, holding the CPU stalled until the image is complete.
module uart_prog_loader #(
  parameter int CLK_FREQ = 16000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              frame_err,
  output logic              overflow
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'((CLKS_PER_BIT / 2) - 1);
  localparam logic [16:0] DEPTH        = 17'(1) << ADDR_W;
  localparam logic [7:0]  SYNC_BYTE    = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    LD_WAIT_SYNC, LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO, LD_DONE
  } ld_state_t;

  logic        rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t   rx_state_r, rx_state_s;
  logic [15:0] cnt_r;
  logic [2:0]  bit_idx_r;
  logic [7:0]  shift_r;
  logic        byte_valid_r;
  logic        tick_s;

  ld_state_t   ld_state_r, ld_state_s;
  logic [7:0]  len_hi_r, data_hi_r;
  logic [15:0] len_r, word_idx_r;
  logic        is_sync_s, len_zero_s, last_word_s, in_range_s;
  logic        we_s, done_s, ovf_s, hold_s;
  logic [ADDR_W-1:0] addr_s;
  logic [15:0] wdata_s;

  // Two-flop synchronizer plus previous-value flop for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Sample strobe: half a bit into the start bit, then whole bit periods
  always_comb begin
    tick_s = 1'b0;
    case (rx_state_r)
      RX_START:         tick_s = (cnt_r == HALF_LAST);
      RX_DATA, RX_STOP: tick_s = (cnt_r == BIT_LAST);
      default:          tick_s = 1'b0;
    endcase
  end

  // RX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state_r <= RX_IDLE;
    else     rx_state_r <= rx_state_s;
  end

  // RX next-state logic; a high start-bit sample is treated as a glitch
  always_comb begin
    rx_state_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE:  if (rx_prev_r && !rx_sync_r) rx_state_s = RX_START; else rx_state_s = RX_IDLE;
      RX_START: if (tick_s) rx_state_s = rx_sync_r ? RX_IDLE : RX_DATA; else rx_state_s = RX_START;
      RX_DATA:  if (tick_s && (bit_idx_r == 3'd7)) rx_state_s = RX_STOP; else rx_state_s = RX_DATA;
      RX_STOP:  if (tick_s) rx_state_s = RX_IDLE; else rx_state_s = RX_STOP;
      default:  rx_state_s = RX_IDLE;
    endcase
  end

  // RX datapath: bit timer, LSB-first shift register, byte/frame-error strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= 16'd0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'd0;
      byte_valid_r <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err    <= 1'b0;
      if ((rx_state_r == RX_IDLE) || tick_s) cnt_r <= 16'd0;
      else                                   cnt_r <= cnt_r + 16'd1;
      if ((rx_state_r == RX_DATA) && tick_s) begin
        shift_r   <= {rx_sync_r, shift_r[7:1]};
        bit_idx_r <= bit_idx_r + 3'd1;
      end else if (rx_state_r != RX_DATA) begin
        bit_idx_r <= 3'd0;
      end
      if ((rx_state_r == RX_STOP) && tick_s) begin
        byte_valid_r <= rx_sync_r;
        frame_err    <= !rx_sync_r;
      end
    end
  end

  assign is_sync_s   = (shift_r == SYNC_BYTE);
  assign len_zero_s  = ({len_hi_r, shift_r} == 16'd0);
  assign last_word_s = (word_idx_r == (len_r - 16'd1));
  assign in_range_s  = ({1'b0, word_idx_r} < DEPTH);

  // Loader state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ld_state_r <= LD_WAIT_SYNC;
    else     ld_state_r <= ld_state_s;
  end

  // Loader next-state logic, advanced only by valid bytes
  always_comb begin
    ld_state_s = ld_state_r;
    if (byte_valid_r) begin
      case (ld_state_r)
        LD_WAIT_SYNC: if (is_sync_s) ld_state_s = LD_LEN_HI; else ld_state_s = LD_WAIT_SYNC;
        LD_LEN_HI:    ld_state_s = LD_LEN_LO;
        LD_LEN_LO:    if (len_zero_s) ld_state_s = LD_DONE; else ld_state_s = LD_DATA_HI;
        LD_DATA_HI:   ld_state_s = LD_DATA_LO;
        LD_DATA_LO:   if (last_word_s) ld_state_s = LD_DONE; else ld_state_s = LD_DATA_HI;
        LD_DONE:      if (is_sync_s) ld_state_s = LD_LEN_HI; else ld_state_s = LD_DONE;
        default:      ld_state_s = LD_WAIT_SYNC;
      endcase
    end else begin
      ld_state_s = ld_state_r;
    end
  end

  // Loader output logic; cpu_hold reasserts as soon as a reload sync byte arrives
  always_comb begin
    we_s    = 1'b0;
    done_s  = 1'b0;
    ovf_s   = overflow;
    hold_s  = (ld_state_r != LD_DONE);
    addr_s  = imem_addr;
    wdata_s = imem_wdata;
    if (byte_valid_r) begin
      case (ld_state_r)
        LD_WAIT_SYNC, LD_DONE: begin
          if (is_sync_s) begin
            ovf_s  = 1'b0;
            hold_s = 1'b1;
          end else begin
            ovf_s  = overflow;
          end
        end
        LD_LEN_LO: begin
          if (len_zero_s) done_s = 1'b1; else done_s = 1'b0;
        end
        LD_DATA_LO: begin
          if (in_range_s) begin
            we_s    = 1'b1;
            addr_s  = word_idx_r[ADDR_W-1:0];
            wdata_s = {data_hi_r, shift_r};
          end else begin
            ovf_s   = 1'b1;
          end
          if (last_word_s) done_s = 1'b1; else done_s = 1'b0;
        end
        default: done_s = 1'b0;
      endcase
    end else begin
      we_s = 1'b0;
    end
  end

  // Loader datapath: length, pending high byte and word index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi_r   <= 8'd0;
      len_r      <= 16'd0;
      data_hi_r  <= 8'd0;
      word_idx_r <= 16'd0;
    end else if (byte_valid_r) begin
      case (ld_state_r)
        LD_WAIT_SYNC, LD_DONE: if (is_sync_s) word_idx_r <= 16'd0;
        LD_LEN_HI:  len_hi_r   <= shift_r;
        LD_LEN_LO:  len_r      <= {len_hi_r, shift_r};
        LD_DATA_HI: data_hi_r  <= shift_r;
        LD_DATA_LO: word_idx_r <= word_idx_r + 16'd1;
        default:    word_idx_r <= word_idx_r;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 16'd0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      imem_we    <= we_s;
      imem_addr  <= addr_s;
      imem_wdata <= wdata_s;
      cpu_hold   <= hold_s;
      load_done  <= done_s;
      overflow   <= ovf_s;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized bench for uart_prog_loader: two instances (256-word and 4-word memories) share
// one serial line and are checked against a byte-level frame-parsing model.
module tb_uart_prog_loader;

  localparam int CLK_FREQ = 1050000;   // 10.5 clocks per bit, truncated to 10
  localparam int BAUD     = 100000;
  localparam int CPB      = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;

  logic we_a, ld_a, fe_a, ov_a, hold_a;
  logic [7:0]  addr_a;
  logic [15:0] wd_a;
  logic we_b, ld_b, fe_b, ov_b, hold_b;
  logic [1:0]  addr_b;
  logic [15:0] wd_b;

  always #5 clk = ~clk;

  uart_prog_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .imem_we(we_a), .imem_addr(addr_a),
    .imem_wdata(wd_a), .cpu_hold(hold_a), .load_done(ld_a), .frame_err(fe_a), .overflow(ov_a));

  uart_prog_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wd_b), .cpu_hold(hold_b), .load_done(ld_b), .frame_err(fe_b), .overflow(ov_b));

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic        done;
    logic        ferr;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int vectors = 0;
  int miscompares = 0;

  // Model state per instance: index 0 = 256 words, index 1 = 4 words
  int          depth_m[2] = '{256, 4};
  bit          in_load_m[2];
  bit          hold_m[2];
  bit          ovf_m[2];
  int          pos_m[2];
  int          n_m[2];
  logic [7:0]  nhi_m[2];
  logic [7:0]  dhi_m[2];
  logic [15:0] laddr_m[2];
  logic [15:0] ldata_m[2];
  int          wr_cnt[2];
  bit          prev_done[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int k, input ev_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      in_load_m[k] = 1'b0;
      hold_m[k]    = 1'b1;
      ovf_m[k]     = 1'b0;
      pos_m[k]     = 0;
      laddr_m[k]   = 16'd0;
      ldata_m[k]   = 16'd0;
      prev_done[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Frame parser: pos counts payload bytes after the sync byte (2 length bytes, then hi/lo pairs)
  task automatic model_byte(input logic [7:0] b, input bit good);
    ev_t e;
    int  w;
    for (int k = 0; k < 2; k++) begin
      e.we = 1'b0; e.addr = 16'd0; e.data = 16'd0; e.done = 1'b0; e.ferr = 1'b0;
      if (!good) begin
        e.ferr = 1'b1;
        push_ev(k, e);
      end else if (!in_load_m[k]) begin
        if (b == 8'hA5) begin
          in_load_m[k] = 1'b1;
          hold_m[k]    = 1'b1;
          ovf_m[k]     = 1'b0;
          pos_m[k]     = 0;
        end
      end else begin
        if (pos_m[k] == 0) begin
          nhi_m[k] = b;
        end else if (pos_m[k] == 1) begin
          n_m[k] = {nhi_m[k], b};
          if (n_m[k] == 0) begin
            e.done = 1'b1;
            push_ev(k, e);
            in_load_m[k] = 1'b0;
            hold_m[k]    = 1'b0;
          end
        end else if (((pos_m[k] - 2) % 2) == 0) begin
          dhi_m[k] = b;
        end else begin
          w      = (pos_m[k] - 2) / 2;
          e.we   = (w < depth_m[k]);
          e.done = (w == n_m[k] - 1);
          if (e.we) begin
            e.addr     = 16'(w % depth_m[k]);
            e.data     = {dhi_m[k], b};
            laddr_m[k] = e.addr;
            ldata_m[k] = e.data;
          end else begin
            ovf_m[k] = 1'b1;
          end
          if (e.we || e.done) push_ev(k, e);
          if (e.done) begin
            in_load_m[k] = 1'b0;
            hold_m[k]    = 1'b0;
          end
        end
        pos_m[k]++;
      end
    end
  endtask

  task automatic cmp_inst(input int k, input logic we, input logic [15:0] addr,
                          input logic [15:0] wd, input logic done, input logic fe,
                          input logic hold);
    ev_t e;
    if (prev_done[k]) begin
      check($sformatf("hold_after_done[%0d]", k), 32'(hold), 32'd0);
      prev_done[k] = 1'b0;
    end
    if (we || done || fe) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        check($sformatf("unexpected_event[%0d]", k), 32'({we, done, fe}), 32'd0);
      end else begin
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("imem_we[%0d]", k), 32'(we), 32'(e.we));
        check($sformatf("load_done[%0d]", k), 32'(done), 32'(e.done));
        check($sformatf("frame_err[%0d]", k), 32'(fe), 32'(e.ferr));
        if (e.we) begin
          check($sformatf("imem_addr[%0d]", k), 32'(addr), 32'(e.addr));
          check($sformatf("imem_wdata[%0d]", k), 32'(wd), 32'(e.data));
        end
        if (we) wr_cnt[k]++;
        if (done) begin
          check($sformatf("hold_at_done[%0d]", k), 32'(hold), 32'd1);
          prev_done[k] = 1'b1;
        end
      end
    end
  endtask

  // Per-cycle compare of strobes, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      cmp_inst(0, we_a, 16'(addr_a), wd_a, ld_a, fe_a, hold_a);
      cmp_inst(1, we_b, 16'(addr_b), wd_b, ld_b, fe_b, hold_b);
    end
  end

  task automatic quiet_check();
    @(negedge clk);
    check("hold_a", 32'(hold_a), 32'(hold_m[0]));
    check("hold_b", 32'(hold_b), 32'(hold_m[1]));
    check("overflow_a", 32'(ov_a), 32'(ovf_m[0]));
    check("overflow_b", 32'(ov_b), 32'(ovf_m[1]));
    check("held_addr_a", 32'(addr_a), 32'(laddr_m[0]));
    check("held_data_a", 32'(wd_a), 32'(ldata_m[0]));
    check("held_addr_b", 32'(addr_b), 32'(laddr_m[1]));
    check("held_data_b", 32'(wd_b), 32'(ldata_m[1]));
    check("pending_a", 32'(q0.size()), 32'd0);
    check("pending_b", 32'(q1.size()), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    model_byte(b, good);
    @(posedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = good;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    quiet_check();
  endtask

  task automatic do_reset();
    @(posedge clk);
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(we_a), 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_wdata", 32'(wd_a), 32'd0);
    check("rst_hold", 32'(hold_a), 32'd1);
    check("rst_done", 32'(ld_a), 32'd0);
    check("rst_ferr", 32'(fe_a), 32'd0);
    check("rst_ovf", 32'(ov_a), 32'd0);
    check("rst_ovf_b", 32'(ov_b), 32'd0);
    rst = 1'b0;
    repeat (2 * CPB) @(posedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int base_a, base_b, n;
    logic [7:0] g;
    wr_cnt[0] = 0;
    wr_cnt[1] = 0;
    do_reset();

    // Two-word image
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    check("t1_writes", 32'(wr_cnt[0]), 32'd2);
    check("t1_addr", 32'(addr_a), 32'd1);
    check("t1_data", 32'(wd_a), 32'h0000ABCD);
    check("t1_hold", 32'(hold_a), 32'd0);

    // Ignored bytes in DONE, then a zero-length reload
    send_byte(8'h00, 1'b1); send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b1);
    check("t2_hold_reload", 32'(hold_a), 32'd1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    check("t2_writes", 32'(wr_cnt[0]), 32'd2);
    check("t2_hold", 32'(hold_a), 32'd0);

    // Frame error during DATA_HI, byte resent
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h77, 1'b0); send_byte(8'h77, 1'b1); send_byte(8'h88, 1'b1);
    check("t3_data", 32'(wd_a), 32'h00007788);
    check("t3_addr", 32'(addr_a), 32'd0);

    // Quarter-bit glitch while idle
    @(posedge clk);
    uart_rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    quiet_check();

    // Five words into the 4-word instance
    base_a = wr_cnt[0];
    base_b = wr_cnt[1];
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'h00, 1'b1);
      send_byte(8'(i), 1'b1);
    end
    check("t5_writes_b", 32'(wr_cnt[1] - base_b), 32'd4);
    check("t5_writes_a", 32'(wr_cnt[0] - base_a), 32'd5);
    check("t5_ovf_b", 32'(ov_b), 32'd1);
    check("t5_ovf_a", 32'(ov_a), 32'd0);
    check("t5_addr_b", 32'(addr_b), 32'd3);
    check("t5_data_b", 32'(wd_b), 32'h00000004);

    // Reset between the length and the first data byte
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h0F, 1'b1); send_byte(8'h0F, 1'b1);
    check("t6_addr", 32'(addr_a), 32'd0);
    check("t6_data", 32'(wd_a), 32'h00000F0F);
    check("t6_hold", 32'(hold_a), 32'd0);

    // Randomized frames with occasional frame errors and leading garbage
    for (int f = 0; f < 8; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, ($urandom_range(0, 9) != 0));
      end
      n = $urandom_range(0, 6);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'(n), 1'b1);
      for (int j = 0; j < 2 * n; j++) begin
        g = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0) send_byte(g, 1'b0);
        send_byte(g, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
